// File: rtl/cache_line_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_line_bank_pkg
// Brief  : Geometry constants, derived widths and FSM encoding for the line bank.
// Rev    : 1.0  initial release
// ============================================================================
package cache_line_bank_pkg;

    localparam int NUM_SETS    = 128;
    localparam int NUM_WAYS    = 4;
    localparam int BLOCK_BYTES = 64;

    localparam int WPB    = BLOCK_BYTES / 4;
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int WOFF_W = $clog2(WPB);
    localparam int ADDR_W = SET_W + WAY_W + WOFF_W;
    localparam int DEPTH  = NUM_SETS * NUM_WAYS * WPB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } state_e;

endpackage : cache_line_bank_pkg
`default_nettype wire

// File: rtl/cache_line_bank_if.sv
`default_nettype none
// ============================================================================
// Module : cache_line_bank_if
// Brief  : CPU word port, line fill and line evict channels of the line bank.
// Rev    : 1.0  initial release
// ============================================================================
interface cache_line_bank_if;
    import cache_line_bank_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [SET_W-1:0]  cpu_set;
    logic [WAY_W-1:0]  cpu_way;
    logic [WOFF_W-1:0] cpu_word;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic [SET_W-1:0]  line_set;
    logic [WAY_W-1:0]  line_way;
    logic              fill_start;
    logic              fill_valid;
    logic [31:0]       fill_data;
    logic              fill_ready;
    logic              fill_done;
    logic              evict_start;
    logic              evict_valid;
    logic [31:0]       evict_data;
    logic              evict_last;
    logic              evict_ready;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_set, cpu_way, cpu_word, cpu_be, cpu_wdata,
        output line_set, line_way, fill_start, fill_valid, fill_data,
        output evict_start, evict_ready,
        input  cpu_ready, cpu_rvalid, cpu_rdata, fill_ready, fill_done,
        input  evict_valid, evict_data, evict_last, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_set, cpu_way, cpu_word, cpu_be, cpu_wdata,
        input  line_set, line_way, fill_start, fill_valid, fill_data,
        input  evict_start, evict_ready,
        output cpu_ready, cpu_rvalid, cpu_rdata, fill_ready, fill_done,
        output evict_valid, evict_data, evict_last, busy
    );

endinterface : cache_line_bank_if
`default_nettype wire

// File: rtl/cache_line_bank_word_ram.sv
`default_nettype none
// ============================================================================
// Module : cache_line_bank_word_ram
// Brief  : 1R1W synchronous word RAM, per-byte write enables, registered read.
// Rev    : 1.0  initial release
// ============================================================================
module cache_line_bank_word_ram #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    // One storage array per byte lane so each lane has a single writer.
    // The read register holds its value when re is low.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && be[b]) begin
                mem[waddr] <= wdata[8*b +: 8];
            end
            if (re) begin
                rd_q <= mem[raddr];
            end
        end

        assign rdata[8*b +: 8] = rd_q;
    end

endmodule : cache_line_bank_word_ram
`default_nettype wire

// File: rtl/cache_line_bank.sv
`default_nettype none
// ============================================================================
// Module : cache_line_bank
// Brief  : Set-associative data storage with CPU word port and fill/evict engines.
// Rev    : 1.0  initial release
// ============================================================================
module cache_line_bank
    import cache_line_bank_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_line_bank_if.slave bus
);

    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WPB - 1);

    state_e            state_q, state_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0]  lset_q, lset_d;
    logic [WAY_W-1:0]  lway_q, lway_d;
    logic              rvalid_q, rvalid_d;
    logic              fill_done_q, fill_done_d;
    logic              ev_valid_q, ev_valid_d;
    logic              ev_last_q, ev_last_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [31:0]       ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lset_d      = lset_q;
        lway_d      = lway_q;
        rvalid_d    = 1'b0;
        fill_done_d = 1'b0;
        ev_valid_d  = ev_valid_q;
        ev_last_d   = ev_last_q;
        ram_we      = 1'b0;
        ram_waddr   = {bus.cpu_set, bus.cpu_way, bus.cpu_word};
        ram_be      = bus.cpu_be;
        ram_wdata   = bus.cpu_wdata;
        ram_re      = 1'b0;
        ram_raddr   = {bus.cpu_set, bus.cpu_way, bus.cpu_word};

        case (state_q)
            ST_IDLE: begin
                if (bus.evict_start) begin
                    // Word 0 is read in the start cycle so the first beat
                    // is presented on the very next cycle.
                    state_d    = ST_EVICT;
                    lset_d     = bus.line_set;
                    lway_d     = bus.line_way;
                    ram_re     = 1'b1;
                    ram_raddr  = {bus.line_set, bus.line_way, {WOFF_W{1'b0}}};
                    cnt_d      = WOFF_W'(1);
                    ev_valid_d = 1'b1;
                    ev_last_d  = 1'b0;
                end else if (bus.fill_start) begin
                    state_d = ST_FILL;
                    lset_d  = bus.line_set;
                    lway_d  = bus.line_way;
                    cnt_d   = '0;
                end else if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_re   = 1'b1;
                        rvalid_d = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                ram_waddr = {lset_q, lway_q, cnt_q};
                ram_be    = 4'hF;
                ram_wdata = bus.fill_data;
                if (bus.fill_valid) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = ST_IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end

            ST_EVICT: begin
                // The RAM read register doubles as the beat register: with no
                // new read issued during a stall, the presented word stays put.
                ram_raddr = {lset_q, lway_q, cnt_q};
                if (bus.evict_ready) begin
                    if (ev_last_q) begin
                        state_d    = ST_IDLE;
                        ev_valid_d = 1'b0;
                        ev_last_d  = 1'b0;
                    end else begin
                        ram_re    = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        ev_last_d = (cnt_q == LAST_WORD);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lset_q      <= '0;
            lway_q      <= '0;
            rvalid_q    <= 1'b0;
            fill_done_q <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lset_q      <= lset_d;
            lway_q      <= lway_d;
            rvalid_q    <= rvalid_d;
            fill_done_q <= fill_done_d;
            ev_valid_q  <= ev_valid_d;
            ev_last_q   <= ev_last_d;
        end
    end

    cache_line_bank_word_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Data outputs are zero whenever their valid is low, including after reset.
    assign bus.cpu_ready   = (state_q == ST_IDLE) && !bus.evict_start && !bus.fill_start;
    assign bus.cpu_rvalid  = rvalid_q;
    assign bus.cpu_rdata   = rvalid_q ? ram_rdata : 32'h0;
    assign bus.fill_ready  = (state_q == ST_FILL);
    assign bus.fill_done   = fill_done_q;
    assign bus.evict_valid = ev_valid_q;
    assign bus.evict_data  = ev_valid_q ? ram_rdata : 32'h0;
    assign bus.evict_last  = ev_last_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule : cache_line_bank
`default_nettype wire

// File: tb/tb_cache_line_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_line_bank
// Brief  : Randomised self-checking bench with a word-array reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_line_bank;
    import cache_line_bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_line_bank_if bus ();

    cache_line_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [int];
    logic [31:0] line_buf [WPB];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int aidx(input int s, input int w, input int wd);
        return (s * NUM_WAYS + w) * WPB + wd;
    endfunction

    task automatic cpu_write(input int s, input int w, input int wd,
                             input logic [3:0] be, input logic [31:0] d);
        logic [31:0] old;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_set   = SET_W'(s);
        bus.cpu_way   = WAY_W'(w);
        bus.cpu_word  = WOFF_W'(wd);
        bus.cpu_be    = be;
        bus.cpu_wdata = d;
        #1;
        check_eq("cpu_ready_wr", 32'(bus.cpu_ready), 32'd1);
        tick();
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        if (model.exists(aidx(s, w, wd)) || be == 4'hF) begin
            old = model.exists(aidx(s, w, wd)) ? model[aidx(s, w, wd)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[b]) old[8*b +: 8] = d[8*b +: 8];
            model[aidx(s, w, wd)] = old;
        end
    endtask

    task automatic cpu_read(input int s, input int w, input int wd, input string tag);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_set  = SET_W'(s);
        bus.cpu_way  = WAY_W'(w);
        bus.cpu_word = WOFF_W'(wd);
        tick();
        bus.cpu_req = 1'b0;
        check_eq({tag, "_rvalid"}, 32'(bus.cpu_rvalid), 32'd1);
        if (model.exists(aidx(s, w, wd)))
            check_eq({tag, "_rdata"}, bus.cpu_rdata, model[aidx(s, w, wd)]);
    endtask

    // mode 0: fill_valid on alternate cycles; mode 1: random gaps.
    // abort_after >= 0 applies reset once that many beats are written.
    task automatic fill_line(input int s, input int w, input int mode, input int abort_after);
        int beat = 0;
        int cyc  = 0;
        bit hs;
        bus.line_set   = SET_W'(s);
        bus.line_way   = WAY_W'(w);
        bus.fill_start = 1'b1;
        tick();
        bus.fill_start = 1'b0;
        check_eq("fill_busy", 32'(bus.busy), 32'd1);
        while (beat < WPB && cyc < 20 * WPB) begin
            bus.fill_valid = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.fill_data  = line_buf[beat];
            hs = bus.fill_valid;
            check_eq("fill_ready", 32'(bus.fill_ready), 32'd1);
            tick();
            cyc++;
            bus.fill_valid = 1'b0;
            if (hs) begin
                model[aidx(s, w, beat)] = line_buf[beat];
                beat++;
            end
            if (abort_after >= 0 && beat == abort_after) break;
            check_eq("fill_done", 32'(bus.fill_done), 32'(beat == WPB));
        end
        if (abort_after >= 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_eq("abort_fill_busy", 32'(bus.busy), 32'd0);
            check_eq("abort_fill_ready", 32'(bus.fill_ready), 32'd0);
            check_eq("abort_fill_done", 32'(bus.fill_done), 32'd0);
            tick();
            check_eq("abort_fill_done2", 32'(bus.fill_done), 32'd0);
        end else begin
            check_eq("fill_beats", 32'(beat), 32'(WPB));
            tick();
            check_eq("fill_done_end", 32'(bus.fill_done), 32'd0);
            check_eq("fill_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    // Drains a line already started; first cycle after start is c=1.
    // mode 0: evict_ready low on cycles 2..4; mode 1: random ready.
    task automatic evict_body(input int s, input int w, input int mode, input int abort_after);
        int  k = 0;
        int  c = 1;
        bit  rdy;
        while (k < WPB && c < 20 * WPB) begin
            rdy = (mode == 0) ? !(c >= 2 && c <= 4) : ($urandom_range(0, 3) != 0);
            bus.evict_ready = rdy;
            check_eq("ev_valid", 32'(bus.evict_valid), 32'd1);
            check_eq("ev_data", bus.evict_data, model[aidx(s, w, k)]);
            check_eq("ev_last", 32'(bus.evict_last), 32'(k == WPB - 1));
            tick();
            c++;
            if (rdy) k++;
            if (abort_after >= 0 && k == abort_after) break;
        end
        bus.evict_ready = 1'b0;
        if (abort_after >= 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end else begin
            check_eq("ev_beats", 32'(k), 32'(WPB));
        end
        check_eq("ev_end_valid", 32'(bus.evict_valid), 32'd0);
        check_eq("ev_end_last", 32'(bus.evict_last), 32'd0);
        check_eq("ev_end_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic evict_line(input int s, input int w, input int mode, input int abort_after);
        bus.line_set    = SET_W'(s);
        bus.line_way    = WAY_W'(w);
        bus.evict_start = 1'b1;
        tick();
        bus.evict_start = 1'b0;
        evict_body(s, w, mode, abort_after);
    endtask

    initial begin
        int ps[8];
        int pw[8];
        int pwd[8];
        int rs, rw;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_set = '0; bus.cpu_way = '0;
        bus.cpu_word = '0; bus.cpu_be = '0; bus.cpu_wdata = '0;
        bus.line_set = '0; bus.line_way = '0; bus.fill_start = 0; bus.fill_valid = 0;
        bus.fill_data = '0; bus.evict_start = 0; bus.evict_ready = 0;

        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check_eq("rst_rdata", bus.cpu_rdata, 32'd0);
        check_eq("rst_fill_done", 32'(bus.fill_done), 32'd0);
        check_eq("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        check_eq("rst_ev_valid", 32'(bus.evict_valid), 32'd0);
        check_eq("rst_ev_last", 32'(bus.evict_last), 32'd0);
        check_eq("rst_ev_data", bus.evict_data, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("idle_cpu_ready", 32'(bus.cpu_ready), 32'd1);

        // Directed CPU word accesses with byte merging
        cpu_write(5, 2, 3, 4'hF, 32'hDEADBEEF);
        cpu_read(5, 2, 3, "rd_full");
        check_eq("rd_full_exact", bus.cpu_rdata, 32'hDEADBEEF);
        cpu_write(5, 2, 3, 4'h1, 32'h000000AA);
        cpu_read(5, 2, 3, "rd_be1");
        check_eq("rd_be1_exact", bus.cpu_rdata, 32'hDEADBEAA);
        tick();
        check_eq("rvalid_pulse", 32'(bus.cpu_rvalid), 32'd0);
        cpu_write(5, 2, 3, 4'h0, 32'h12345678);
        cpu_read(5, 2, 3, "rd_be0");

        // Random CPU traffic over a small pool of fully initialised words
        for (int i = 0; i < 8; i++) begin
            ps[i]  = $urandom_range(0, NUM_SETS - 1);
            pw[i]  = $urandom_range(0, NUM_WAYS - 1);
            pwd[i] = $urandom_range(0, WPB - 1);
            cpu_write(ps[i], pw[i], pwd[i], 4'hF, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            int p = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1)
                cpu_write(ps[p], pw[p], pwd[p], 4'($urandom_range(0, 15)), $urandom);
            else
                cpu_read(ps[p], pw[p], pwd[p], "rnd_rd");
        end

        // Line fill with alternating valid, then read back through the CPU port
        for (int i = 0; i < WPB; i++) line_buf[i] = 32'h100 + 32'(i);
        fill_line(127, 3, 0, -1);
        bus.fill_valid = 1'b1;
        bus.fill_data  = 32'hFFFF_FFFF;
        repeat (3) tick();
        bus.fill_valid = 1'b0;
        for (int i = 0; i < WPB; i++) cpu_read(127, 3, i, "fill_rd");

        // Eviction with a stall window
        evict_line(127, 3, 0, -1);

        // All three starts together: eviction wins, fill and CPU request dropped
        bus.line_set    = SET_W'(127);
        bus.line_way    = WAY_W'(3);
        bus.evict_start = 1'b1;
        bus.fill_start  = 1'b1;
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b0;
        #1;
        check_eq("prio_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        tick();
        bus.evict_start = 1'b0;
        bus.fill_start  = 1'b0;
        bus.cpu_req     = 1'b0;
        check_eq("prio_fill_ready", 32'(bus.fill_ready), 32'd0);
        check_eq("prio_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        evict_body(127, 3, 1, -1);
        check_eq("prio_after_fill", 32'(bus.fill_ready), 32'd0);

        // Random line: random fill gaps and random downstream backpressure
        rs = $urandom_range(0, NUM_SETS - 1);
        rw = $urandom_range(0, NUM_WAYS - 1);
        for (int i = 0; i < WPB; i++) line_buf[i] = $urandom;
        fill_line(rs, rw, 1, -1);
        evict_line(rs, rw, 1, -1);
        cpu_read(rs, rw, $urandom_range(0, WPB - 1), "rnd_line_rd");

        // Reset in the middle of a fill keeps the beats already written
        for (int i = 0; i < WPB; i++) line_buf[i] = 32'hA500_0000 + 32'(i);
        fill_line(10, 1, 1, 7);
        for (int i = 0; i < 7; i++) cpu_read(10, 1, i, "abort_fill_rd");

        // Reset in the middle of an eviction
        evict_line(127, 3, 1, 5);
        cpu_read(127, 3, 15, "post_abort_rd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule : tb_cache_line_bank
`default_nettype wire
